// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the two-stage RISC-V core and its run controller.
//   - Default program-memory address width and fetch-to-writeback depth.
//   - run_state encodings (IDLE/RUN/DRAIN/HALTED) and the FSM enum built on them.
//   - halt_cause encodings (NONE/HOST/BREAK/STEP) and a cause-priority helper.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam int DEFAULT_PIPE_DEPTH = 2;

  // Run-state encodings as seen by the host/debug side.
  localparam logic [1:0] RS_IDLE   = 2'd0;
  localparam logic [1:0] RS_RUN    = 2'd1;
  localparam logic [1:0] RS_DRAIN  = 2'd2;
  localparam logic [1:0] RS_HALTED = 2'd3;

  // Halt-cause encodings.
  localparam logic [1:0] HC_NONE  = 2'd0;
  localparam logic [1:0] HC_HOST  = 2'd1;
  localparam logic [1:0] HC_BREAK = 2'd2;
  localparam logic [1:0] HC_STEP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = RS_IDLE,
    ST_RUN    = RS_RUN,
    ST_DRAIN  = RS_DRAIN,
    ST_HALTED = RS_HALTED
  } run_state_t;

  // Several stop sources can be active in the same cycle; the host request
  // wins over a breakpoint, and a breakpoint wins over the single-step stop.
  function automatic logic [1:0] pick_cause(input logic host_stop,
                                            input logic break_stop);
    logic [1:0] cause;
    if (host_stop) begin
      cause = HC_HOST;
    end else if (break_stop) begin
      cause = HC_BREAK;
    end else begin
      cause = HC_STEP;
    end
    return cause;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping, so a host reading
// it can tell "very large" from "small after overflow".
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset (count returns to 0)
//   inc    in   count this cycle
//   count  out  current value, WIDTH bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != COUNT_MAX)) begin
      count_reg <= count_reg + COUNT_ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_run_controller.sv
// ---------------------------------------------------------------------------
// pipeline_run_controller
// Run / halt / single-step sequencer for the two-stage pipeline core. Gates
// the program counter through pc_en, drains in-flight instructions before
// reporting halted, stops on a breakpoint fetch address and keeps saturating
// cycle and retired-instruction counters.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   start_req      in   begin / resume free-running execution
//   halt_req       in   stop fetching and drain
//   step_req       in   execute exactly one instruction from HALTED
//   bp_en          in   breakpoint enable
//   bp_addr        in   breakpoint fetch address
//   pc_address     in   current PC from the program counter
//   pc_en          out  PC advance / fetch enable (combinational)
//   run_state      out  IDLE=0, RUN=1, DRAIN=2, HALTED=3
//   halted         out  high while in HALTED
//   halt_cause     out  NONE=0, HOST=1, BREAK=2, STEP=3
//   halted_pc      out  PC captured when draining starts
//   cycle_count    out  cycles spent outside IDLE, saturating
//   retired_count  out  instructions reaching writeback, saturating
// ---------------------------------------------------------------------------
module pipeline_run_controller
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_req,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  bp_en,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic [ADDR_WIDTH-1:0] pc_address,
  output logic                  pc_en,
  output logic [1:0]            run_state,
  output logic                  halted,
  output logic [1:0]            halt_cause,
  output logic [ADDR_WIDTH-1:0] halted_pc,
  output logic [31:0]           cycle_count,
  output logic [31:0]           retired_count
);

  // The drain counter holds PIPE_DEPTH-1 down to 0; keep it at least 1 bit.
  localparam int                 DRAIN_W    = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_DEPTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  run_state_t            state_reg;
  logic [DRAIN_W-1:0]    drain_cnt_reg;
  logic                  step_mode_reg;     // current RUN stint is a single step
  logic                  step_fetched_reg;  // the single instruction has been fetched
  logic                  bp_skip_reg;       // ignore breakpoint on first cycle after resume
  logic [1:0]            halt_cause_reg;
  logic [ADDR_WIDTH-1:0] halted_pc_reg;

  logic bp_hit;
  logic stop;
  logic step_cycle;

  // -------------------------------------------------------------------------
  // Stop decode and fetch enable
  // -------------------------------------------------------------------------
  always_comb begin
    bp_hit     = bp_en && (pc_address == bp_addr) && !bp_skip_reg;
    stop       = halt_req || bp_hit || step_mode_reg;
    // The step stint fetches once, even though step_mode already asserts stop.
    step_cycle = step_mode_reg && !step_fetched_reg;
    pc_en      = 1'b0;
    if (state_reg == ST_RUN) begin
      pc_en = step_cycle || !stop;
    end
  end

  // -------------------------------------------------------------------------
  // Run-state machine
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      drain_cnt_reg    <= '0;
      step_mode_reg    <= 1'b0;
      step_fetched_reg <= 1'b0;
      bp_skip_reg      <= 1'b0;
      halt_cause_reg   <= HC_NONE;
      halted_pc_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_req) begin
            state_reg        <= ST_RUN;
            step_mode_reg    <= 1'b0;
            step_fetched_reg <= 1'b0;
            bp_skip_reg      <= 1'b0;
          end
        end

        ST_RUN: begin
          // The skip only shields the PC we resumed at.
          bp_skip_reg <= 1'b0;
          if (step_cycle) begin
            // Stop is evaluated again next cycle, so halted_pc captures the
            // PC after the stepped instruction.
            step_fetched_reg <= 1'b1;
          end else if (stop) begin
            state_reg        <= ST_DRAIN;
            halt_cause_reg   <= pick_cause(halt_req, bp_hit);
            halted_pc_reg    <= pc_address;
            drain_cnt_reg    <= DRAIN_INIT;
            step_mode_reg    <= 1'b0;
            step_fetched_reg <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= ST_HALTED;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - DRAIN_ONE;
          end
        end

        ST_HALTED: begin
          // Start beats step when both are requested.
          if (start_req) begin
            state_reg        <= ST_RUN;
            step_mode_reg    <= 1'b0;
            step_fetched_reg <= 1'b0;
            bp_skip_reg      <= 1'b1;
          end else if (step_req) begin
            state_reg        <= ST_RUN;
            step_mode_reg    <= 1'b1;
            step_fetched_reg <= 1'b0;
            bp_skip_reg      <= 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Retire tracking: pc_en delayed by PIPE_DEPTH stages marks an instruction
  // reaching writeback. retire_chain[0] is the live fetch, retire_chain[k]
  // is the output of shift stage k-1.
  // -------------------------------------------------------------------------
  logic [PIPE_DEPTH:0] retire_chain;

  assign retire_chain[0] = pc_en;

  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_retire
    logic stage_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stage_reg <= 1'b0;
      end else begin
        stage_reg <= retire_chain[gi];
      end
    end

    assign retire_chain[gi+1] = stage_reg;
  end

  // -------------------------------------------------------------------------
  // Counters
  // -------------------------------------------------------------------------
  logic cycle_inc;
  logic retire_inc;

  assign cycle_inc  = (state_reg != ST_IDLE);
  assign retire_inc = retire_chain[PIPE_DEPTH];

  sat_counter #(
    .WIDTH (32)
  ) u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (cycle_inc),
    .count (cycle_count)
  );

  sat_counter #(
    .WIDTH (32)
  ) u_retired_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_inc),
    .count (retired_count)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign run_state  = state_reg;
  assign halted     = (state_reg == ST_HALTED);
  assign halt_cause = halt_cause_reg;
  assign halted_pc  = halted_pc_reg;

endmodule

// File: tb/tb_pipeline_run_controller.sv
module tb_pipeline_run_controller;
  import cpu_pkg::*;

  localparam int AW = 7;
  localparam int PD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_req = 1'b0;
  logic          halt_req = 1'b0;
  logic          step_req = 1'b0;
  logic          bp_en = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic [AW-1:0] pc;
  logic          pc_en;
  logic [1:0]    run_state;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [AW-1:0] halted_pc;
  logic [31:0]   cycle_count;
  logic [31:0]   retired_count;

  // Program-counter model driven by the DUT's pc_en, with a load port.
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_load_val = '0;

  // Narrow counter instance for the saturation corner.
  logic          sat_inc = 1'b0;
  logic [3:0]    sat_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int en_cnt;
  logic [AW-1:0] pc_snap;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= '0;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_en)   pc <= pc + 7'd1;
  end

  pipeline_run_controller #(
    .ADDR_WIDTH (AW),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .start_req     (start_req),
    .halt_req      (halt_req),
    .step_req      (step_req),
    .bp_en         (bp_en),
    .bp_addr       (bp_addr),
    .pc_address    (pc),
    .pc_en         (pc_en),
    .run_state     (run_state),
    .halted        (halted),
    .halt_cause    (halt_cause),
    .halted_pc     (halted_pc),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  sat_counter #(
    .WIDTH (4)
  ) u_sat (
    .clk   (clk),
    .reset (rst_n),
    .inc   (sat_inc),
    .count (sat_cnt)
  );

  typedef struct {
    logic        start;
    logic        halt;
    logic        step;
    logic        e_pc_en;
    logic [1:0]  e_state;
    logic        e_halted;
    logic [1:0]  e_cause;
    logic [6:0]  e_hpc;
    logic [31:0] e_retired;
    logic [31:0] e_cycles;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic s, input logic h, input logic st,
                              input logic pe, input logic [1:0] rs, input logic hl,
                              input logic [1:0] hc, input logic [6:0] hp,
                              input logic [31:0] rt, input logic [31:0] cy);
    vec_t v;
    v.start = s; v.halt = h; v.step = st;
    v.e_pc_en = pe; v.e_state = rs; v.e_halted = hl;
    v.e_cause = hc; v.e_hpc = hp; v.e_retired = rt; v.e_cycles = cy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!halted && n < 10) begin
      tick();
      n++;
    end
    check(name, halted, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " run_state"}, run_state, RS_IDLE);
    check({tag, " pc_en"}, pc_en, 0);
    check({tag, " halted"}, halted, 0);
    check({tag, " halt_cause"}, halt_cause, HC_NONE);
    check({tag, " halted_pc"}, halted_pc, 0);
    check({tag, " cycle_count"}, cycle_count, 0);
    check({tag, " retired_count"}, retired_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Breakpoint at 5 from PC 0, then a single step off the breakpoint.
    //             st h  sp  pe state      hl hc        hpc rt cy
    vecs[0]  = mk(1, 0, 0,  0, RS_IDLE,   0, HC_NONE,  0,  0, 0);
    vecs[1]  = mk(0, 0, 0,  1, RS_RUN,    0, HC_NONE,  0,  0, 0);
    vecs[2]  = mk(0, 0, 0,  1, RS_RUN,    0, HC_NONE,  0,  0, 1);
    vecs[3]  = mk(0, 0, 0,  1, RS_RUN,    0, HC_NONE,  0,  0, 2);
    vecs[4]  = mk(0, 0, 0,  1, RS_RUN,    0, HC_NONE,  0,  1, 3);
    vecs[5]  = mk(0, 0, 0,  1, RS_RUN,    0, HC_NONE,  0,  2, 4);
    vecs[6]  = mk(0, 0, 0,  0, RS_RUN,    0, HC_NONE,  0,  3, 5);
    vecs[7]  = mk(0, 0, 0,  0, RS_DRAIN,  0, HC_BREAK, 5,  4, 6);
    vecs[8]  = mk(0, 0, 0,  0, RS_DRAIN,  0, HC_BREAK, 5,  5, 7);
    vecs[9]  = mk(0, 0, 0,  0, RS_HALTED, 1, HC_BREAK, 5,  5, 8);
    vecs[10] = mk(0, 0, 1,  0, RS_HALTED, 1, HC_BREAK, 5,  5, 9);
    vecs[11] = mk(0, 0, 0,  1, RS_RUN,    0, HC_BREAK, 5,  5, 10);
    vecs[12] = mk(0, 0, 0,  0, RS_RUN,    0, HC_BREAK, 5,  5, 11);
    vecs[13] = mk(0, 0, 0,  0, RS_DRAIN,  0, HC_STEP,  6,  5, 12);
    vecs[14] = mk(0, 0, 0,  0, RS_DRAIN,  0, HC_STEP,  6,  6, 13);
    vecs[15] = mk(0, 0, 0,  0, RS_HALTED, 1, HC_STEP,  6,  6, 14);
    vecs[16] = mk(0, 1, 0,  0, RS_HALTED, 1, HC_STEP,  6,  6, 15);
    vecs[17] = mk(0, 0, 0,  0, RS_HALTED, 1, HC_STEP,  6,  6, 16);

    // ---- Reset values (asynchronous assert before any clock edge)
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- IDLE ignores halt/step
    halt_req = 1'b1; step_req = 1'b1;
    #1 check("idle pc_en", pc_en, 0);
    tick();
    halt_req = 1'b0; step_req = 1'b0;
    check("idle ignores step", run_state, RS_IDLE);
    $display("txn idle: state=%0d cycles=%0d", run_state, cycle_count);

    // ---- Free run for 20 cycles
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i == 0) check("first run pc_en", pc_en, 1);
      if (pc_en) en_cnt++;
      tick();
    end
    check("run pc_en cycles", en_cnt, 20);
    check("run cycle_count", cycle_count, 20);
    check("run retired_count", retired_count, 20 - PD);
    check("run pc", pc, 20);
    $display("txn run20: cycles=%0d retired=%0d pc=%0d", cycle_count, retired_count, pc);

    // ---- Host halt latency
    halt_req = 1'b1;
    #1 check("halt same-cycle pc_en", pc_en, 0);
    tick();
    halt_req = 1'b0;
    check("halt drain state", run_state, RS_DRAIN);
    check("halt cause", halt_cause, HC_HOST);
    check("halt pc", halted_pc, 20);
    tick();
    check("halt not early", halted, 0);
    tick();
    check("halt after depth+1", halted, 1);
    check("halt retired", retired_count, 20);
    check("halt cycles", cycle_count, 23);
    $display("txn halt: state=%0d cause=%0d hpc=%0d", run_state, halt_cause, halted_pc);

    // ---- Breakpoint + single-step table
    do_reset();
    bp_en = 1'b1;
    bp_addr = 7'd5;
    for (int r = 0; r < 18; r++) begin
      start_req = vecs[r].start;
      halt_req  = vecs[r].halt;
      step_req  = vecs[r].step;
      #1;
      check($sformatf("vec%0d pc_en", r), pc_en, vecs[r].e_pc_en);
      check($sformatf("vec%0d state", r), run_state, vecs[r].e_state);
      check($sformatf("vec%0d halted", r), halted, vecs[r].e_halted);
      check($sformatf("vec%0d cause", r), halt_cause, vecs[r].e_cause);
      check($sformatf("vec%0d halted_pc", r), halted_pc, vecs[r].e_hpc);
      check($sformatf("vec%0d retired", r), retired_count, vecs[r].e_retired);
      check($sformatf("vec%0d cycles", r), cycle_count, vecs[r].e_cycles);
      $display("txn vec%0d: pc=%0d pc_en=%0b state=%0d cause=%0d hpc=%0d", r, pc, pc_en,
               run_state, halt_cause, halted_pc);
      tick();
    end
    start_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    check("step pc", pc, 6);

    // ---- Host halt and breakpoint in the same cycle: host wins
    bp_addr = 7'd8;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    tick();
    check("pri pc at bp", pc, 8);
    halt_req = 1'b1;
    #1 check("pri pc_en", pc_en, 0);
    tick();
    halt_req = 1'b0;
    check("pri cause", halt_cause, HC_HOST);
    check("pri halted_pc", halted_pc, 8);
    wait_halted("pri halted");
    $display("txn host+bp: cause=%0d hpc=%0d", halt_cause, halted_pc);

    // ---- start+step together: free run, no step stop
    bp_en = 1'b0;
    start_req = 1'b1; step_req = 1'b1;
    tick();
    start_req = 1'b0; step_req = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (pc_en) en_cnt++;
      tick();
    end
    check("start+step fetches", en_cnt, 6);
    check("start+step state", run_state, RS_RUN);
    $display("txn start+step: state=%0d pc=%0d", run_state, pc);

    // ---- start+halt together from HALTED: zero fetches, host drain
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_halted("pre start+halt halted");
    pc_snap = pc;
    start_req = 1'b1; halt_req = 1'b1;
    tick();
    start_req = 1'b0;
    check("start+halt run", run_state, RS_RUN);
    #1 check("start+halt pc_en", pc_en, 0);
    tick();
    halt_req = 1'b0;
    check("start+halt drain", run_state, RS_DRAIN);
    check("start+halt cause", halt_cause, HC_HOST);
    check("start+halt pc held", pc, pc_snap);
    check("start+halt halted_pc", halted_pc, pc_snap);
    wait_halted("start+halt halted");
    $display("txn start+halt: cause=%0d hpc=%0d", halt_cause, halted_pc);

    // ---- Reset during DRAIN
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("rst drain state", run_state, RS_DRAIN);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst in drain");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("rst no late retire", retired_count, 0);
    check("rst idle cycles", cycle_count, 0);
    $display("txn reset-in-drain: state=%0d retired=%0d", run_state, retired_count);

    // ---- PC wrap is not a stop
    pc_load = 1'b1; pc_load_val = 7'd126;
    tick();
    pc_load = 1'b0;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (pc_en) en_cnt++;
      tick();
    end
    check("wrap fetches", en_cnt, 5);
    check("wrap pc", pc, 3);
    check("wrap state", run_state, RS_RUN);
    $display("txn wrap: pc=%0d state=%0d", pc, run_state);

    // ---- Saturation on a narrow counter
    sat_inc = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat below max", sat_cnt, 14);
    for (int i = 0; i < 6; i++) tick();
    check("sat holds max", sat_cnt, 15);
    sat_inc = 1'b0;
    tick();
    check("sat idle hold", sat_cnt, 15);
    $display("txn sat: count=%0d", sat_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
